uart_apb_arbiter: RTL and testbench
===================================

# uart_apb_arbiter

APB master and two-port round-robin arbiter that shares the single APB slave port of `uart_apb` between two requesters, e.g. a UART polling engine and a host command path. Each requester issues one transfer at a time over a simple valid/done handshake. The block sequences the APB setup and access phases, waits on `pready`, and returns read data and error status. A bounded wait-state timeout guarantees that a hung slave cannot lock the bus.

## Interface
Parameters:
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width; `pstrb` width is `DATA_W/8`
- `TIMEOUT`, 255, maximum ACCESS cycles with `pready`=0 before abort; minimum 1

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic is rising-edge
- `resetn`  in  1  asynchronous, active-low reset
- `reqN_valid`  in  1  N∈{0,1}; transfer request; held with its fields stable until `reqN_done`
- `reqN_write`  in  1  1=write, 0=read
- `reqN_addr`  in  ADDR_W  byte address
- `reqN_wdata`  in  DATA_W  write data
- `reqN_strb`  in  DATA_W/8  write strobes; forced to 0 on reads
- `reqN_done`  out  1  one-cycle completion pulse
- `reqN_rdata`  out  DATA_W  read data; valid with `done`, held until that requester's next `done`
- `reqN_err`  out  1  `pslverr` or timeout; valid with `done`, held like `rdata`
- `psel`, `penable`  out  1  APB control
- `pprot`  out  3  constant 3'b000
- `paddr`  out  ADDR_W; `pwrite`  out  1; `pwdata`  out  DATA_W; `pstrb`  out  DATA_W/8
- `pready`  in  1; `prdata`  in  DATA_W; `pslverr`  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any `reqN_valid`, grant, latch that requester's write/addr/wdata/strb into APB output registers, and go to SETUP. Otherwise stay in IDLE with `psel`=0.
- Arbitration: if only one requester is valid, it wins. If both are valid, the requester not granted last wins. `last_grant` resets to 1, so req0 wins the first tie.
- SETUP: `psel`=1, `penable`=0. Next state is unconditionally ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - `pready`=1: capture `prdata` (reads only; writes leave `reqN_rdata` unchanged) and `pslverr` into the granted requester's registers, then go to DONE.
  - Timeout: the wait counter increments on each ACCESS cycle with `pready`=0. When the counter equals TIMEOUT, set err=1, leave rdata unchanged, and go to DONE.
- DONE: `psel`=`penable`=0. Pulse `reqN_done` for the granted requester. Valid inputs are not sampled. Next state is IDLE.
- Requesters deassert `valid` or present a new request in the cycle after `done`.
- APB address and data outputs hold their last values when idle. Only `psel`/`penable` return to 0.

## Timing
- Reset (asynchronous, immediate): state=IDLE; `psel`, `penable`, `pwrite`=0; `paddr`, `pwdata`, `pstrb`=0; both `done`, `rdata`, and `err`=0; `last_grant`=1; wait counter=0.
- Reset mid-transfer aborts without a `done` pulse. APB is released in the same cycle reset asserts.
- Latency with a zero-wait slave: valid sampled in IDLE at cycle 0, SETUP at 1, ACCESS at 2, DONE (pulse) at 3, IDLE at 4. Each wait state adds 1 cycle.
- Back-to-back throughput: one transfer per 4 cycles minimum.
- A valid request raised during SETUP, ACCESS, or DONE is first sampled in the next IDLE cycle.
- Wait counter: `$clog2(TIMEOUT+1)` bits, cleared on entry to SETUP. It never wraps, because the abort fires at equality.
- `pready` is ignored outside ACCESS.

## Structure
- Shared package `uart_apb_pkg`: FSM state enum (IDLE/SETUP/ACCESS/DONE), `PPROT_DEFAULT`=3'b000, and the default ADDR_W/DATA_W constants.
- Single module with no sub-modules. Round-robin logic is inline because there are only two requesters.

## Test plan
- Zero-wait read: req0 read addr 0x04 with `prdata`=0xDEADBEEF and `pready` tied 1 -> `psel` high in cycles 1–2, `penable` high in cycle 2, `req0_done` at cycle 3, `req0_rdata`=0xDEADBEEF, `req0_err`=0.
- Write with 3 wait states: req1 write 0x00, data 0x41, strb 4'h1 -> `paddr`/`pwdata`/`pstrb` stable through ACCESS, `req1_done` at cycle 6, `req1_rdata` unchanged.
- Contention: both requesters assert valid continuously for 4 transfers -> grant order 0, 1, 0, 1; each `done` exactly 4 cycles apart.
- Slave error: `pslverr`=1 with `pready` -> `reqN_err`=1 at `done`; the next clean transfer clears it to 0.
- Timeout with TIMEOUT=8: `pready` held 0 -> `done` with err=1 after 8 ACCESS cycles; `psel`=0 in the DONE cycle.
- Reset mid-ACCESS: drop `resetn` during a wait state -> `psel`/`penable` go to 0 immediately, no `done` pulse; after release, req0 wins the first tie.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared types and defaults for the UART APB slave-port access path.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_e;

  localparam logic [2:0] PPROT_DEFAULT  = 3'b000;
  localparam int         ADDR_W_DEFAULT = 32;
  localparam int         DATA_W_DEFAULT = 32;

endpackage

// File: rtl/uart_apb_arbiter.sv
// Two-requester round-robin APB master sharing the uart_apb slave port.
//
// state  | meaning
// IDLE   | bus released; arbitrate and latch the winning request
// SETUP  | psel=1, penable=0
// ACCESS | psel=1, penable=1; wait on pready, abort on wait-state timeout
// DONE   | bus released; done pulse to the granted requester
module uart_apb_arbiter
  import uart_apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req0_valid,
  input  logic                req0_write,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_strb,
  output logic                req0_done,
  output logic [DATA_W-1:0]   req0_rdata,
  output logic                req0_err,
  input  logic                req1_valid,
  input  logic                req1_write,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_strb,
  output logic                req1_done,
  output logic [DATA_W-1:0]   req1_rdata,
  output logic                req1_err,
  output logic                psel,
  output logic                penable,
  output logic [2:0]          pprot,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  apb_state_e        state_q, state_d;
  logic              grant_q, last_grant_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              any_valid, pick, capture, abort;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_strb;

  // On a tie the requester that did not win last time gets the bus.
  assign any_valid = req0_valid | req1_valid;
  assign pick      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign sel_write = pick ? req1_write : req0_write;
  assign sel_addr  = pick ? req1_addr  : req0_addr;
  assign sel_wdata = pick ? req1_wdata : req0_wdata;
  assign sel_strb  = pick ? req1_strb  : req0_strb;

  assign pprot     = PPROT_DEFAULT;
  assign req0_done = (state_q == DONE) && !grant_q;
  assign req1_done = (state_q == DONE) &&  grant_q;

  always_comb begin
    state_d = state_q;
    psel    = 1'b0;
    penable = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (any_valid) state_d = SETUP;
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This wait cycle brings the count to TIMEOUT, so the counter never wraps.
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      pstrb        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_valid) begin
        grant_q      <= pick;
        last_grant_q <= pick;
        wait_cnt_q   <= '0;
        pwrite       <= sel_write;
        paddr        <= sel_addr;
        pwdata       <= sel_wdata;
        pstrb        <= sel_write ? sel_strb : '0;
      end else if (state_q == ACCESS && !pready) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;
    end else if (capture || abort) begin
      if (!grant_q) begin
        if (capture && !pwrite) req0_rdata <= prdata;
        req0_err <= abort ? 1'b1 : pslverr;
      end else begin
        if (capture && !pwrite) req1_rdata <= prdata;
        req1_err <= abort ? 1'b1 : pslverr;
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Directed bench for uart_apb_arbiter: scoreboard of expected completions plus an APB slave model.
module tb_uart_apb_arbiter;

  localparam int TMO = 8;

  logic        clk, resetn;
  logic        req0_valid, req0_write, req0_done, req0_err;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic [3:0]  req0_strb;
  logic        req1_valid, req1_write, req1_done, req1_err;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic [3:0]  req1_strb;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [2:0]  pprot;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;

  typedef struct {
    int          id;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] m_rdata [2];
  logic        m_err [2];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_cnt = 0;
  int          acc_cnt  = 0;
  int          p;

  uart_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .psel(psel), .penable(penable), .pprot(pprot), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Expected completion; the per-requester model tracks held rdata/err.
  task automatic push(input int id, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int waits, input logic slverr,
                      input logic [31:0] rd, input int exp_cyc);
    xfer_t e;
    e.id = id; e.write = wr; e.addr = addr; e.wdata = wdata;
    e.strb = wr ? strb : 4'h0;
    e.waits = waits; e.slverr = slverr; e.prdata = rd; e.exp_cyc = exp_cyc;
    if (waits >= TMO) begin
      m_err[id] = 1'b1;
    end else begin
      m_err[id] = slverr;
      if (!wr) m_rdata[id] = rd;
    end
    e.exp_rdata = m_rdata[id];
    e.exp_err   = m_err[id];
    q.push_back(e);
  endtask

  task automatic drive(input int id, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    if (id == 0) begin
      req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_strb = strb; req0_valid = 1'b1;
    end else begin
      req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_strb = strb; req1_valid = 1'b1;
    end
  endtask

  task automatic sync(output int pe);
    @(posedge clk); #1;
    pe = edge_cnt;
  endtask

  task automatic finish_wait(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("pending_after_budget", 64'(q.size()), 64'd0);
    q.delete();
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // APB slave: returns the in-flight scoreboard entry's data after its wait states.
  always @(negedge clk) begin
    if (resetn && psel && q.size() > 0) begin
      chk("paddr",  64'(paddr),  64'(q[0].addr));
      chk("pwrite", 64'(pwrite), 64'(q[0].write));
      chk("pstrb",  64'(pstrb),  64'(q[0].strb));
      if (q[0].write) chk("pwdata", 64'(pwdata), 64'(q[0].wdata));
    end
    if (psel && penable) begin
      if (q.size() > 0 && acc_cnt == q[0].waits) begin
        pready = 1'b1; prdata = q[0].prdata; pslverr = q[0].slverr;
      end else begin
        pready = 1'b0; prdata = 32'hBAD0_0000 | 32'(acc_cnt); pslverr = 1'b0;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0; pready = 1'b1; prdata = 32'hFFFF_FFFF; pslverr = 1'b0;
    end
  end

  // Completion monitor: pop and compare on each done pulse.
  always @(negedge clk) begin
    xfer_t e;
    if (resetn && (req0_done || req1_done)) begin
      chk("done_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("done_id",  64'({req1_done, req0_done}), (e.id == 1) ? 64'd2 : 64'd1);
        chk("done_cyc", 64'(edge_cnt), 64'(e.exp_cyc));
        chk("rdata", (e.id == 1) ? 64'(req1_rdata) : 64'(req0_rdata), 64'(e.exp_rdata));
        chk("err",   (e.id == 1) ? 64'(req1_err)   : 64'(req0_err),   64'(e.exp_err));
        chk("bus_released_in_done", 64'({psel, penable}), 64'd0);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0; req0_strb = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0; req1_strb = 0;
    pready = 1'b1; prdata = 32'hFFFF_FFFF; pslverr = 1'b0;
    m_rdata[0] = 0; m_rdata[1] = 0; m_err[0] = 0; m_err[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel_penable", 64'({psel, penable}), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr",  64'(paddr),  64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_pstrb",  64'(pstrb),  64'd0);
    chk("rst_pprot",  64'(pprot),  64'd0);
    chk("rst_done",   64'({req1_done, req0_done}), 64'd0);
    chk("rst_rdata",  64'({req1_rdata, req0_rdata}), 64'd0);
    chk("rst_err",    64'({req1_err, req0_err}), 64'd0);
    resetn = 1'b1;

    // Zero-wait read on req0
    sync(p);
    push(0, 1'b0, 32'h04, 32'h0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, p + 3);
    drive(0, 1'b0, 32'h04, 32'h0, 4'hF);
    @(posedge clk); #1;
    chk("c1_setup", 64'({psel, penable}), 64'd2);
    @(posedge clk); #1;
    chk("c2_access", 64'({psel, penable}), 64'd3);
    finish_wait(20);

    // Write with three wait states on req1
    sync(p);
    push(1, 1'b1, 32'h00, 32'h41, 4'h1, 3, 1'b0, 32'h1234_5678, p + 6);
    drive(1, 1'b1, 32'h00, 32'h41, 4'h1);
    finish_wait(20);

    // Contention: both held valid for four transfers
    sync(p);
    push(0, 1'b0, 32'h08, 32'h0, 4'hF, 0, 1'b0, 32'h1111_0001, p + 3);
    push(1, 1'b0, 32'h0C, 32'h0, 4'hF, 0, 1'b0, 32'h2222_0002, p + 7);
    push(0, 1'b0, 32'h08, 32'h0, 4'hF, 0, 1'b0, 32'h1111_0003, p + 11);
    push(1, 1'b0, 32'h0C, 32'h0, 4'hF, 0, 1'b0, 32'h2222_0004, p + 15);
    drive(0, 1'b0, 32'h08, 32'h0, 4'hF);
    drive(1, 1'b0, 32'h0C, 32'h0, 4'hF);
    finish_wait(40);

    // Slave error, then a clean transfer clears err
    sync(p);
    push(0, 1'b1, 32'h10, 32'h55, 4'h3, 1, 1'b1, 32'h0, p + 4);
    drive(0, 1'b1, 32'h10, 32'h55, 4'h3);
    finish_wait(20);
    sync(p);
    push(0, 1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D, p + 3);
    drive(0, 1'b0, 32'h14, 32'h0, 4'h0);
    finish_wait(20);

    // Timeout: slave never ready
    sync(p);
    push(1, 1'b0, 32'h18, 32'h0, 4'h0, 100, 1'b0, 32'h0, p + 2 + TMO);
    drive(1, 1'b0, 32'h18, 32'h0, 4'h0);
    finish_wait(30);

    // Reset during an ACCESS wait state
    sync(p);
    push(0, 1'b0, 32'h1C, 32'h0, 4'h0, 100, 1'b0, 32'h0, p + 2 + TMO);
    drive(0, 1'b0, 32'h1C, 32'h0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_mid_bus", 64'({psel, penable}), 64'd0);
    chk("rst_mid_done", 64'({req1_done, req0_done}), 64'd0);
    chk("rst_mid_rdata0", 64'(req0_rdata), 64'd0);
    chk("rst_mid_err1", 64'(req1_err), 64'd0);
    q.delete();
    req0_valid = 1'b0;
    m_rdata[0] = 0; m_rdata[1] = 0; m_err[0] = 0; m_err[1] = 0;
    repeat (8) @(posedge clk);
    #1;
    resetn = 1'b1;

    // First tie after reset goes to req0
    sync(p);
    push(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'hA5A5_0000, p + 3);
    push(1, 1'b1, 32'h24, 32'h99, 4'hC, 2, 1'b0, 32'h0, p + 9);
    drive(0, 1'b0, 32'h20, 32'h0, 4'h0);
    drive(1, 1'b1, 32'h24, 32'h99, 4'hC);
    @(posedge clk); #1;
    chk("tie_grant_addr", 64'(paddr), 64'h20);
    finish_wait(30);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
